// File: rtl/pipe_hazard_unit_if.sv
// pipe_hazard_unit_if: decode-stage hazard query bundle between the pipeline and the hazard unit
interface pipe_hazard_unit_if #(
  parameter int REG_AW = 5,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [REG_AW-1:0] id_ra_addr;
  logic              id_use_ra;
  logic [REG_AW-1:0] id_rb_addr;
  logic              id_use_rb;
  logic [REG_AW-1:0] id_rt_addr;
  logic              id_use_rt;
  logic              id_do_reg_write;
  logic [REG_AW-1:0] id_write_addr;
  logic              id_is_load;
  logic              branch_flush;
  logic              stall;
  logic              flush_id;
  logic [SEL_W-1:0]  fwd_ra_sel;
  logic [SEL_W-1:0]  fwd_rb_sel;
  logic [SEL_W-1:0]  fwd_rt_sel;
  logic [SEL_W:0]    inflight;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;
  modport master (
    output id_valid, id_ra_addr, id_use_ra, id_rb_addr, id_use_rb, id_rt_addr, id_use_rt,
           id_do_reg_write, id_write_addr, id_is_load, branch_flush,
    input  stall, flush_id, fwd_ra_sel, fwd_rb_sel, fwd_rt_sel, inflight, stall_cnt, flush_cnt
  );
  modport slave (
    input  id_valid, id_ra_addr, id_use_ra, id_rb_addr, id_use_rb, id_rt_addr, id_use_rt,
           id_do_reg_write, id_write_addr, id_is_load, branch_flush,
    output stall, flush_id, fwd_ra_sel, fwd_rb_sel, fwd_rt_sel, inflight, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: in-flight write scoreboard driving forwarding selects, load-use stall and branch flush
module pipe_hazard_unit #(
  parameter int REG_AW     = 5,
  parameter int NUM_STAGES = 3,
  parameter int LOAD_READY = 2,
  parameter int SEL_W      = 2,
  parameter int CNT_W      = 16
) (
  input logic clock,
  input logic reset,
  pipe_hazard_unit_if.slave hz
);
  logic [NUM_STAGES-1:0] v, w, ld;
  logic [REG_AW-1:0]     a [NUM_STAGES];
  logic [REG_AW-1:0]     src [3];
  logic [2:0]            use_s, lu;
  logic [SEL_W-1:0]      sel [3];
  logic [SEL_W:0]        cnt;
  logic [CNT_W-1:0]      stall_cnt, flush_cnt;
  logic                  stall, enter;
  assign src[0] = hz.id_ra_addr;
  assign src[1] = hz.id_rb_addr;
  assign src[2] = hz.id_rt_addr;
  assign use_s  = {hz.id_use_rt, hz.id_use_rb, hz.id_use_ra};
  // Scan oldest to youngest so the youngest matching stage overwrites and wins.
  always_comb begin
    for (int s = 0; s < 3; s++) begin
      sel[s] = '0;
      lu[s]  = 1'b0;
      for (int k = NUM_STAGES - 1; k >= 0; k--)
        if (use_s[s] && v[k] && w[k] && a[k] == src[s] && src[s] != '0) begin
          sel[s] = SEL_W'(k + 1);
          lu[s]  = ld[k] && (k < LOAD_READY);
        end
    end
  end
  always_comb begin
    cnt = '0;
    for (int k = 0; k < NUM_STAGES; k++) cnt = cnt + (SEL_W + 1)'(v[k] & w[k]);
  end
  assign stall = hz.id_valid && |lu && !hz.branch_flush;
  assign enter = hz.id_valid && !stall && !hz.branch_flush;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      v         <= '0;
      w         <= '0;
      ld        <= '0;
      for (int k = 0; k < NUM_STAGES; k++) a[k] <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      v    <= {v[NUM_STAGES-2:0], enter};
      w    <= {w[NUM_STAGES-2:0], hz.id_do_reg_write};
      ld   <= {ld[NUM_STAGES-2:0], hz.id_is_load};
      a[0] <= hz.id_write_addr;
      for (int k = 1; k < NUM_STAGES; k++) a[k] <= a[k-1];
      if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (hz.branch_flush && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  assign hz.stall      = stall;
  assign hz.flush_id   = hz.branch_flush;
  assign hz.fwd_ra_sel = sel[0];
  assign hz.fwd_rb_sel = sel[1];
  assign hz.fwd_rt_sel = sel[2];
  assign hz.inflight   = cnt;
  assign hz.stall_cnt  = stall_cnt;
  assign hz.flush_cnt  = flush_cnt;
endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb_pipe_hazard_unit: directed scenarios for forwarding, load-use stall, flush priority and counter saturation
module tb_pipe_hazard_unit;
  logic clock, reset;
  int vectors = 0, miscompares = 0;
  pipe_hazard_unit_if #(.REG_AW(5), .SEL_W(2), .CNT_W(16)) ifc ();
  pipe_hazard_unit_if #(.REG_AW(5), .SEL_W(2), .CNT_W(4))  ifc4 ();
  pipe_hazard_unit #(.REG_AW(5), .NUM_STAGES(3), .LOAD_READY(2), .SEL_W(2), .CNT_W(16))
    dut (.clock(clock), .reset(reset), .hz(ifc));
  pipe_hazard_unit #(.REG_AW(5), .NUM_STAGES(3), .LOAD_READY(2), .SEL_W(2), .CNT_W(4))
    dut4 (.clock(clock), .reset(reset), .hz(ifc4));
  assign ifc4.id_valid        = ifc.id_valid;
  assign ifc4.id_ra_addr      = ifc.id_ra_addr;
  assign ifc4.id_use_ra       = ifc.id_use_ra;
  assign ifc4.id_rb_addr      = ifc.id_rb_addr;
  assign ifc4.id_use_rb       = ifc.id_use_rb;
  assign ifc4.id_rt_addr      = ifc.id_rt_addr;
  assign ifc4.id_use_rt       = ifc.id_use_rt;
  assign ifc4.id_do_reg_write = ifc.id_do_reg_write;
  assign ifc4.id_write_addr   = ifc.id_write_addr;
  assign ifc4.id_is_load      = ifc.id_is_load;
  assign ifc4.branch_flush    = ifc.branch_flush;
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic drive(input logic vld, input logic [4:0] ra, input logic ura,
                       input logic [4:0] rb, input logic urb, input logic [4:0] rt, input logic urt,
                       input logic wr, input logic [4:0] wa, input logic ldi, input logic bf);
    ifc.id_valid = vld;  ifc.id_ra_addr = ra; ifc.id_use_ra = ura;
    ifc.id_rb_addr = rb; ifc.id_use_rb = urb; ifc.id_rt_addr = rt; ifc.id_use_rt = urt;
    ifc.id_do_reg_write = wr; ifc.id_write_addr = wa; ifc.id_is_load = ldi; ifc.branch_flush = bf;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 5'd3, 1, 5'd3, 1, 5'd3, 1, 1, 5'd3, i[0], 0);
      tick();
      if (ifc.stall !== 1'b0) begin $display("FAIL reset_stall got %0d exp 0", ifc.stall); miscompares++; end
      vectors++;
      if (ifc.fwd_ra_sel !== 2'd0 || ifc.fwd_rb_sel !== 2'd0 || ifc.fwd_rt_sel !== 2'd0) begin
        $display("FAIL reset_fwd got %0d/%0d/%0d exp 0/0/0", ifc.fwd_ra_sel, ifc.fwd_rb_sel, ifc.fwd_rt_sel);
        miscompares++;
      end
      vectors++;
      if (ifc.inflight !== 3'd0) begin $display("FAIL reset_inflight got %0d exp 0", ifc.inflight); miscompares++; end
      vectors++;
    end
    if (ifc.stall_cnt !== 16'd0 || ifc.flush_cnt !== 16'd0 || ifc.flush_id !== 1'b0) begin
      $display("FAIL reset_counters got stall_cnt=%0d flush_cnt=%0d flush_id=%0d exp 0/0/0",
               ifc.stall_cnt, ifc.flush_cnt, ifc.flush_id);
      miscompares++;
    end
    vectors++;
    idle();
    reset = 1'b1;
  endtask

  task automatic test_alu_chain();
    logic [1:0] exp_sel [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic [2:0] exp_inf [4] = '{3'd1, 3'd1, 3'd1, 3'd0};
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 1, 5'd3, 0, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1, 5'd3, 1, 5'd4, 1, 5'd3, 1, 0, 0, 0, 0);
      if (ifc.fwd_ra_sel !== exp_sel[i] || ifc.fwd_rt_sel !== exp_sel[i] || ifc.fwd_rb_sel !== 2'd0) begin
        $display("FAIL alu_chain[%0d] got ra=%0d rb=%0d rt=%0d exp ra=%0d rb=0 rt=%0d", i,
                 ifc.fwd_ra_sel, ifc.fwd_rb_sel, ifc.fwd_rt_sel, exp_sel[i], exp_sel[i]);
        miscompares++;
      end
      vectors++;
      if (ifc.inflight !== exp_inf[i] || ifc.stall !== 1'b0) begin
        $display("FAIL alu_inflight[%0d] got inflight=%0d stall=%0d exp %0d/0", i, ifc.inflight, ifc.stall, exp_inf[i]);
        miscompares++;
      end
      vectors++;
      tick();
    end
    idle();
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 1, 5'd5, 1, 0);
    tick();
    drive(1, 0, 0, 5'd5, 1, 0, 0, 1, 5'd6, 0, 0);
    if (ifc.stall !== 1'b1 || ifc.fwd_rb_sel !== 2'd1) begin
      $display("FAIL load_use_c1 got stall=%0d rb=%0d exp 1/1", ifc.stall, ifc.fwd_rb_sel); miscompares++;
    end
    vectors++;
    tick();
    if (ifc.stall !== 1'b1 || ifc.fwd_rb_sel !== 2'd2) begin
      $display("FAIL load_use_c2 got stall=%0d rb=%0d exp 1/2", ifc.stall, ifc.fwd_rb_sel); miscompares++;
    end
    vectors++;
    tick();
    if (ifc.stall !== 1'b0 || ifc.fwd_rb_sel !== 2'd3 || ifc.stall_cnt !== 16'd2) begin
      $display("FAIL load_use_c3 got stall=%0d rb=%0d stall_cnt=%0d exp 0/3/2", ifc.stall, ifc.fwd_rb_sel, ifc.stall_cnt);
      miscompares++;
    end
    vectors++;
    tick();
    idle();
    if (ifc.inflight !== 3'd1) begin $display("FAIL load_use_enter got inflight=%0d exp 1", ifc.inflight); miscompares++; end
    vectors++;
  endtask

  task automatic test_youngest();
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 1, 5'd7, 0, 0);
    tick();
    idle();
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 1, 5'd7, 0, 0);
    tick();
    drive(1, 5'd7, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    if (ifc.fwd_ra_sel !== 2'd1 || ifc.inflight !== 3'd2) begin
      $display("FAIL youngest got ra=%0d inflight=%0d exp 1/2", ifc.fwd_ra_sel, ifc.inflight); miscompares++;
    end
    vectors++;
    drive(1, 0, 0, 0, 0, 0, 0, 1, 5'd0, 1, 0);
    tick();
    drive(1, 5'd0, 1, 5'd7, 1, 0, 0, 0, 0, 0, 0);
    if (ifc.fwd_ra_sel !== 2'd0 || ifc.fwd_rb_sel !== 2'd2 || ifc.stall !== 1'b0) begin
      $display("FAIL r0_no_hazard got ra=%0d rb=%0d stall=%0d exp 0/2/0", ifc.fwd_ra_sel, ifc.fwd_rb_sel, ifc.stall);
      miscompares++;
    end
    vectors++;
    if (ifc.inflight !== 3'd2) begin $display("FAIL r0_inflight got %0d exp 2", ifc.inflight); miscompares++; end
    vectors++;
    idle();
  endtask

  task automatic test_flush_vs_stall();
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 1, 5'd5, 1, 0);
    tick();
    drive(1, 0, 0, 5'd5, 1, 0, 0, 1, 5'd6, 0, 1);
    if (ifc.stall !== 1'b0 || ifc.flush_id !== 1'b1) begin
      $display("FAIL flush_prio got stall=%0d flush_id=%0d exp 0/1", ifc.stall, ifc.flush_id); miscompares++;
    end
    vectors++;
    tick();
    drive(1, 5'd6, 1, 5'd5, 1, 0, 0, 0, 0, 0, 0);
    if (ifc.flush_cnt !== 16'd1 || ifc.stall_cnt !== 16'd0 || ifc.flush_id !== 1'b0) begin
      $display("FAIL flush_cnt got flush_cnt=%0d stall_cnt=%0d flush_id=%0d exp 1/0/0", ifc.flush_cnt, ifc.stall_cnt, ifc.flush_id);
      miscompares++;
    end
    vectors++;
    if (ifc.inflight !== 3'd1 || ifc.fwd_ra_sel !== 2'd0 || ifc.fwd_rb_sel !== 2'd2 || ifc.stall !== 1'b1) begin
      $display("FAIL flush_bubble got inflight=%0d ra=%0d rb=%0d stall=%0d exp 1/0/2/1",
               ifc.inflight, ifc.fwd_ra_sel, ifc.fwd_rb_sel, ifc.stall);
      miscompares++;
    end
    vectors++;
    idle();
  endtask

  task automatic test_saturation();
    do_reset();
    drive(1, 5'd5, 1, 0, 0, 0, 0, 1, 5'd5, 1, 0);
    for (int i = 0; i < 31; i++) tick();
    if (ifc.stall_cnt !== 16'd20) begin $display("FAIL sat_wide got %0d exp 20", ifc.stall_cnt); miscompares++; end
    vectors++;
    if (ifc4.stall_cnt !== 4'd15) begin $display("FAIL sat_narrow got %0d exp 15", ifc4.stall_cnt); miscompares++; end
    vectors++;
    if (ifc.stall !== 1'b1) begin $display("FAIL sat_pre_reset_stall got %0d exp 1", ifc.stall); miscompares++; end
    vectors++;
    reset = 1'b0;
    #1;
    if (ifc.stall !== 1'b0 || ifc.fwd_ra_sel !== 2'd0 || ifc.inflight !== 3'd0) begin
      $display("FAIL async_reset_state got stall=%0d ra=%0d inflight=%0d exp 0/0/0", ifc.stall, ifc.fwd_ra_sel, ifc.inflight);
      miscompares++;
    end
    vectors++;
    if (ifc.stall_cnt !== 16'd0 || ifc4.stall_cnt !== 4'd0) begin
      $display("FAIL async_reset_cnt got %0d/%0d exp 0/0", ifc.stall_cnt, ifc4.stall_cnt); miscompares++;
    end
    vectors++;
    idle();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    test_reset();
    test_alu_chain();
    test_load_use();
    test_youngest();
    test_flush_vs_stall();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
